// File: rtl/hoplite_route_ctrl_if.sv
// Link-side bundle for one Hoplite node controller.
// The DUT side is "slave"; the environment (links, PE, external mux) is "master".
interface hoplite_route_ctrl_if #(
  parameter int P_W   = 32,
  parameter int CNT_W = 16
);
  logic [P_W-1:0]   w_in;
  logic             w_valid;
  logic [P_W-1:0]   n_in;
  logic             n_valid;
  logic [P_W-1:0]   pe_in;
  logic             pe_in_valid;
  logic             pe_in_ready;
  logic [1:0]       sel;
  logic [P_W-1:0]   mux_outx;
  logic [P_W-1:0]   mux_outy;
  logic [P_W-1:0]   e_out;
  logic             e_valid;
  logic [P_W-1:0]   s_out;
  logic             s_valid;
  logic [P_W-1:0]   pe_out;
  logic             pe_out_valid;
  logic [CNT_W-1:0] deflect_cnt;
  logic [CNT_W-1:0] stall_cnt;

  modport slave (
    input  w_in, w_valid, n_in, n_valid, pe_in, pe_in_valid, mux_outx, mux_outy,
    output pe_in_ready, sel, e_out, e_valid, s_out, s_valid, pe_out, pe_out_valid,
    deflect_cnt, stall_cnt
  );

  modport master (
    output w_in, w_valid, n_in, n_valid, pe_in, pe_in_valid, mux_outx, mux_outy,
    input  pe_in_ready, sel, e_out, e_valid, s_out, s_valid, pe_out, pe_out_valid,
    deflect_cnt, stall_cnt
  );
endinterface

// File: rtl/hoplite_route_ctrl.sv
// Hoplite node controller: decodes W/N/PE destinations, drives the output mux
// select, registers the E/S links, ejects local traffic and keeps statistics.
module hoplite_route_ctrl #(
  parameter int P_W   = 32,
  parameter int X_W   = 2,
  parameter int Y_W   = 2,
  parameter int MY_X  = 0,
  parameter int MY_Y  = 0,
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  hoplite_route_ctrl_if.slave   bus
);
  localparam logic [X_W-1:0] MX = MY_X[X_W-1:0];
  localparam logic [Y_W-1:0] MY = MY_Y[Y_W-1:0];

  // mux select encodings: E source / S source
  localparam logic [1:0] SEL_WN = 2'b00;
  localparam logic [1:0] SEL_NW = 2'b01;
  localparam logic [1:0] SEL_PN = 2'b10;
  localparam logic [1:0] SEL_WP = 2'b11;

  function automatic logic on_col(input logic [P_W-1:0] p);
    return p[P_W-1 -: X_W] == MX;
  endfunction

  function automatic logic on_row(input logic [P_W-1:0] p);
    return p[P_W-1-X_W -: Y_W] == MY;
  endfunction

  logic n_self, w_self, n_act, w_act, w_s, pe_s;
  logic inject, e_nxt, s_nxt, deflect, stall;

  assign n_self = bus.n_valid & on_col(bus.n_in) & on_row(bus.n_in);
  assign w_self = bus.w_valid & on_col(bus.w_in) & on_row(bus.w_in) & ~n_self;
  assign n_act  = bus.n_valid & ~n_self;
  assign w_act  = bus.w_valid & ~w_self;
  // a W packet that lost ejection to N still has dst_x == MY_X, so it asks for S
  assign w_s    = on_col(bus.w_in);
  assign pe_s   = on_col(bus.pe_in);

  always_comb begin
    bus.sel = SEL_WN;
    inject  = 1'b0;
    e_nxt   = 1'b0;
    s_nxt   = 1'b0;
    deflect = 1'b0;
    case ({n_act, w_act})
      2'b11: begin
        e_nxt   = 1'b1;
        s_nxt   = 1'b1;
        deflect = w_s;
      end
      2'b10: begin
        s_nxt = 1'b1;
        if (bus.pe_in_valid && !pe_s) begin
          bus.sel = SEL_PN;
          inject  = 1'b1;
          e_nxt   = 1'b1;
        end
      end
      2'b01: begin
        if (w_s) begin
          bus.sel = SEL_NW;
          s_nxt   = 1'b1;
        end else begin
          e_nxt = 1'b1;
          if (bus.pe_in_valid && pe_s) begin
            bus.sel = SEL_WP;
            inject  = 1'b1;
            s_nxt   = 1'b1;
          end
        end
      end
      default: begin
        if (bus.pe_in_valid) begin
          bus.sel = pe_s ? SEL_WP : SEL_PN;
          inject  = 1'b1;
          e_nxt   = ~pe_s;
          s_nxt   = pe_s;
        end
      end
    endcase
  end

  assign bus.pe_in_ready = inject;
  assign stall           = bus.pe_in_valid & ~inject;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.e_out        <= '0;
      bus.e_valid      <= 1'b0;
      bus.s_out        <= '0;
      bus.s_valid      <= 1'b0;
      bus.pe_out       <= '0;
      bus.pe_out_valid <= 1'b0;
      bus.deflect_cnt  <= '0;
      bus.stall_cnt    <= '0;
    end else begin
      bus.e_out        <= bus.mux_outx;
      bus.s_out        <= bus.mux_outy;
      bus.e_valid      <= e_nxt;
      bus.s_valid      <= s_nxt;
      bus.pe_out_valid <= n_self | w_self;
      if (n_self)      bus.pe_out <= bus.n_in;
      else if (w_self) bus.pe_out <= bus.w_in;
      if (deflect && bus.deflect_cnt != '1) bus.deflect_cnt <= bus.deflect_cnt + 1'b1;
      if (stall && bus.stall_cnt != '1)     bus.stall_cnt   <= bus.stall_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_hoplite_route_ctrl.sv
// Directed bench for hoplite_route_ctrl at node (1,2); a second CNT_W=2 copy
// shares the stimulus to exercise counter saturation.
module tb_hoplite_route_ctrl;
  localparam int P_W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hoplite_route_ctrl_if #(.P_W(P_W), .CNT_W(16)) ifa ();
  hoplite_route_ctrl_if #(.P_W(P_W), .CNT_W(2))  ifb ();

  hoplite_route_ctrl #(.P_W(P_W), .X_W(2), .Y_W(2), .MY_X(1), .MY_Y(2), .CNT_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ifa));
  hoplite_route_ctrl #(.P_W(P_W), .X_W(2), .Y_W(2), .MY_X(1), .MY_Y(2), .CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ifb));

  // external router mux model
  function automatic logic [2*P_W-1:0] mux_f(input logic [1:0] s,
      input logic [P_W-1:0] w, input logic [P_W-1:0] n, input logic [P_W-1:0] p);
    case (s)
      2'b00:   return {w, n};
      2'b01:   return {n, w};
      2'b10:   return {p, n};
      default: return {w, p};
    endcase
  endfunction

  assign {ifa.mux_outx, ifa.mux_outy} = mux_f(ifa.sel, ifa.w_in, ifa.n_in, ifa.pe_in);
  assign {ifb.mux_outx, ifb.mux_outy} = mux_f(ifb.sel, ifb.w_in, ifb.n_in, ifb.pe_in);
  assign ifb.w_in        = ifa.w_in;
  assign ifb.w_valid     = ifa.w_valid;
  assign ifb.n_in        = ifa.n_in;
  assign ifb.n_valid     = ifa.n_valid;
  assign ifb.pe_in       = ifa.pe_in;
  assign ifb.pe_in_valid = ifa.pe_in_valid;

  function automatic logic [P_W-1:0] pk(input int x, input int y, input int pl);
    logic [27:0] p;
    logic [1:0] xx, yy;
    p = pl[27:0]; xx = x[1:0]; yy = y[1:0];
    return {xx, yy, p};
  endfunction

  typedef struct {
    logic nv; logic [P_W-1:0] n;
    logic wv; logic [P_W-1:0] w;
    logic pv; logic [P_W-1:0] p;
    logic [1:0] sel; logic rdy;
    logic ev; logic [P_W-1:0] eo;
    logic sv; logic [P_W-1:0] so;
    logic pov; logic [P_W-1:0] po;
  } vec_t;

  int compared = 0;
  int mismatched = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic nv, input logic [P_W-1:0] n, input logic wv,
                       input logic [P_W-1:0] w, input logic pv, input logic [P_W-1:0] p);
    ifa.n_valid = nv; ifa.n_in = n;
    ifa.w_valid = wv; ifa.w_in = w;
    ifa.pe_in_valid = pv; ifa.pe_in = p;
  endtask

  task automatic idle();
    drive(1'b0, '0, 1'b0, '0, 1'b0, '0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle();
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
  endtask

  // one cycle: drive at negedge, check comb outputs, check registers after posedge
  task automatic apply(input int i, input vec_t v);
    @(negedge clk);
    drive(v.nv, v.n, v.wv, v.w, v.pv, v.p);
    #1;
    chk($sformatf("v%0d sel", i), 64'(ifa.sel), 64'(v.sel));
    chk($sformatf("v%0d pe_in_ready", i), 64'(ifa.pe_in_ready), 64'(v.rdy));
    @(posedge clk);
    #1;
    chk($sformatf("v%0d e_valid", i), 64'(ifa.e_valid), 64'(v.ev));
    chk($sformatf("v%0d s_valid", i), 64'(ifa.s_valid), 64'(v.sv));
    chk($sformatf("v%0d pe_out_valid", i), 64'(ifa.pe_out_valid), 64'(v.pov));
    if (v.ev)  chk($sformatf("v%0d e_out", i), 64'(ifa.e_out), 64'(v.eo));
    if (v.sv)  chk($sformatf("v%0d s_out", i), 64'(ifa.s_out), 64'(v.so));
    if (v.pov) chk($sformatf("v%0d pe_out", i), 64'(ifa.pe_out), 64'(v.po));
  endtask

  function automatic vec_t mk(input logic nv, input logic [P_W-1:0] n, input logic wv,
      input logic [P_W-1:0] w, input logic pv, input logic [P_W-1:0] p,
      input logic [1:0] sel, input logic rdy, input logic ev, input logic [P_W-1:0] eo,
      input logic sv, input logic [P_W-1:0] so, input logic pov, input logic [P_W-1:0] po);
    vec_t v;
    v.nv = nv; v.n = n; v.wv = wv; v.w = w; v.pv = pv; v.p = p;
    v.sel = sel; v.rdy = rdy; v.ev = ev; v.eo = eo; v.sv = sv; v.so = so;
    v.pov = pov; v.po = po;
    return v;
  endfunction

  vec_t vt[14];

  initial begin
    logic [P_W-1:0] a, b, c, d1, d2, z;
    a  = pk(1, 3, 'h0AAA);
    b  = pk(3, 2, 'h0BBB);
    c  = pk(1, 0, 'h0CCC);
    d1 = pk(1, 2, 'h0D01);
    d2 = pk(1, 2, 'h0D02);
    z  = '0;

    //           nv n   wv w   pv p   sel    rdy ev eo  sv so  pov po
    vt[0]  = mk(0, z,  0, z,  0, z,  2'b00, 0,  0, z,  0, z,  0, z);
    vt[1]  = mk(1, a,  1, c,  0, z,  2'b00, 0,  1, c,  1, a,  0, z);
    vt[2]  = mk(1, a,  1, c,  1, b,  2'b00, 0,  1, c,  1, a,  0, z);
    vt[3]  = mk(1, a,  0, z,  1, b,  2'b10, 1,  1, b,  1, a,  0, z);
    vt[4]  = mk(1, a,  0, z,  1, c,  2'b00, 0,  0, z,  1, a,  0, z);
    vt[5]  = mk(0, z,  1, b,  1, c,  2'b11, 1,  1, b,  1, c,  0, z);
    vt[6]  = mk(0, z,  1, b,  0, z,  2'b00, 0,  1, b,  0, z,  0, z);
    vt[7]  = mk(0, z,  1, c,  1, b,  2'b01, 0,  0, z,  1, c,  0, z);
    vt[8]  = mk(0, z,  0, z,  1, b,  2'b10, 1,  1, b,  0, z,  0, z);
    vt[9]  = mk(0, z,  0, z,  1, a,  2'b11, 1,  0, z,  1, a,  0, z);
    vt[10] = mk(1, d1, 1, d2, 0, z,  2'b01, 0,  0, z,  1, d2, 1, d1);
    vt[11] = mk(1, a,  1, d2, 0, z,  2'b00, 0,  0, z,  1, a,  1, d2);
    vt[12] = mk(1, d1, 0, z,  1, b,  2'b10, 1,  1, b,  0, z,  1, d1);
    vt[13] = mk(0, z,  0, z,  1, d1, 2'b11, 1,  0, z,  1, d1, 0, z);

    idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset e_valid", 64'(ifa.e_valid), 64'd0);
    chk("reset s_valid", 64'(ifa.s_valid), 64'd0);
    chk("reset pe_out_valid", 64'(ifa.pe_out_valid), 64'd0);
    chk("reset deflect_cnt", 64'(ifa.deflect_cnt), 64'd0);
    chk("reset stall_cnt", 64'(ifa.stall_cnt), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vt[i]) apply(i, vt[i]);
    // deflections: v1, v2; stalls: v2, v4, v7
    chk("table deflect_cnt", 64'(ifa.deflect_cnt), 64'd2);
    chk("table stall_cnt", 64'(ifa.stall_cnt), 64'd3);

    // reset mid-traffic: registered valids high, then async reset between edges
    apply(100, vt[1]);
    apply(101, vt[10]);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async rst e_valid", 64'(ifa.e_valid), 64'd0);
    chk("async rst s_valid", 64'(ifa.s_valid), 64'd0);
    chk("async rst pe_out_valid", 64'(ifa.pe_out_valid), 64'd0);
    chk("async rst deflect_cnt", 64'(ifa.deflect_cnt), 64'd0);
    chk("async rst stall_cnt", 64'(ifa.stall_cnt), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // six back-to-back conflicts
    do_reset();
    for (int k = 0; k < 6; k++) apply(200 + k, vt[1]);
    chk("sat deflect_cnt (16b)", 64'(ifa.deflect_cnt), 64'd6);
    chk("sat deflect_cnt (2b)", 64'(ifb.deflect_cnt), 64'd3);

    // PE stalled behind a W packet turning south for 5 cycles
    do_reset();
    for (int k = 0; k < 5; k++) apply(300 + k, vt[7]);
    chk("stall stall_cnt", 64'(ifa.stall_cnt), 64'd5);
    chk("stall stall_cnt (2b)", 64'(ifb.stall_cnt), 64'd3);
    chk("stall deflect_cnt", 64'(ifa.deflect_cnt), 64'd0);

    // deflection and stall in the same cycle bump both
    do_reset();
    apply(400, vt[2]);
    chk("coincide deflect_cnt", 64'(ifa.deflect_cnt), 64'd1);
    chk("coincide stall_cnt", 64'(ifa.stall_cnt), 64'd1);

    @(negedge clk);
    idle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
